// File: rtl/param_wt_cache.sv
// param_wt_cache: parametrised direct-mapped, write-through, no-write-allocate
// cache with one data word per line and a req/ack RAM handshake.
// Optional statistics counters are enabled by defining PARAM_WT_CACHE_STATS_EN.
module param_wt_cache #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned INDEX_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              flush,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_valid,
   output logic              cpu_busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
`ifdef PARAM_WT_CACHE_STATS_EN
   ,
   output logic [15:0]       stat_hits,
   output logic [15:0]       stat_misses
`endif
);

   localparam int unsigned LINES  = 1 << INDEX_W;
   localparam int unsigned TAG_W  = ADDR_W - INDEX_W;
   localparam int unsigned STAT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // line storage; only the valid bits are reset
   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];

   // lookup of the incoming request and of the outstanding miss
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] miss_idx;
   logic [TAG_W-1:0]   miss_tag;
   logic               hit;
   logic               accept;

   // next values of registered outputs
   logic              cpu_valid_d;
   logic [DATA_W-1:0] cpu_rdata_d;
   logic              mem_req_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;

   // line update controls
   logic               line_data_we;
   logic               line_fill;
   logic               clear_all;
   logic [INDEX_W-1:0] wr_idx;
   logic [TAG_W-1:0]   wr_tag;
   logic [DATA_W-1:0]  wr_data;

   assign req_idx  = cpu_addr[INDEX_W-1:0];
   assign req_tag  = cpu_addr[ADDR_W-1:INDEX_W];
   assign miss_idx = mem_addr[INDEX_W-1:0];
   assign miss_tag = mem_addr[ADDR_W-1:INDEX_W];
   assign hit      = valid_q[req_idx] & (tag_mem[req_idx] == req_tag);

   // a request is taken only in IDLE and never alongside a flush
   assign accept   = (state == IDLE) & cpu_req & ~flush;
   assign cpu_busy = (state != IDLE) | flush;

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (cpu_we) begin
                  state_next = WR_THRU;
               end else if (!hit) begin
                  state_next = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            if (mem_ack) begin
               state_next = IDLE;
            end
         end
         WR_THRU: begin
            if (mem_ack) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // output and line-update decode
   always_comb begin
      cpu_valid_d  = 1'b0;
      cpu_rdata_d  = cpu_rdata;
      mem_req_d    = mem_req;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      line_data_we = 1'b0;
      line_fill    = 1'b0;
      clear_all    = 1'b0;
      wr_idx       = req_idx;
      wr_tag       = req_tag;
      wr_data      = cpu_wdata;
      case (state)
         IDLE: begin
            if (flush) begin
               clear_all = 1'b1;
            end else if (cpu_req) begin
               if (cpu_we) begin
                  // write-through; cached copy refreshed only on a hit
                  line_data_we = hit;
                  mem_req_d    = 1'b1;
                  mem_we_d     = 1'b1;
                  mem_addr_d   = cpu_addr;
                  mem_wdata_d  = cpu_wdata;
               end else if (hit) begin
                  cpu_valid_d = 1'b1;
                  cpu_rdata_d = data_mem[req_idx];
               end else begin
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = cpu_addr;
               end
            end
         end
         RD_MISS: begin
            if (mem_ack) begin
               // refill the line from the returned word
               line_data_we = 1'b1;
               line_fill    = 1'b1;
               wr_idx       = miss_idx;
               wr_tag       = miss_tag;
               wr_data      = mem_rdata;
               cpu_rdata_d  = mem_rdata;
               cpu_valid_d  = 1'b1;
               mem_req_d    = 1'b0;
            end
         end
         WR_THRU: begin
            if (mem_ack) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               cpu_valid_d = 1'b1;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   // registered CPU and RAM side outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_valid <= 1'b0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         cpu_valid <= cpu_valid_d;
         cpu_rdata <= cpu_rdata_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
      end
   end

   // valid bits: cleared as a whole on reset or flush, set on refill
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (clear_all) begin
         valid_q <= '0;
      end else if (line_fill) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // tag and data arrays, no reset needed since valid gates every use
   always_ff @(posedge clk) begin
      if (line_data_we) begin
         data_mem[wr_idx] <= wr_data;
      end
      if (line_fill) begin
         tag_mem[wr_idx] <= wr_tag;
      end
   end

`ifdef PARAM_WT_CACHE_STATS_EN
   // saturating hit/miss counters over accepted accesses
   always_ff @(posedge clk) begin
      if (reset || clear_all) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (accept) begin
         if (hit) begin
            if (stat_hits != {STAT_W{1'b1}}) begin
               stat_hits <= stat_hits + STAT_W'(1);
            end
         end else begin
            if (stat_misses != {STAT_W{1'b1}}) begin
               stat_misses <= stat_misses + STAT_W'(1);
            end
         end
      end
   end
`else
   // statistics disabled: no counters are built
`endif

endmodule
